// File: rtl/wishbone_bus_router.sv
// rtl/wishbone_bus_router.sv - registered Wishbone classic address router with unmapped, timeout and slave-error responses
// Decodes base/mask windows, forwards one transfer at a time to the latched slave.
module wishbone_bus_router #(
  parameter int                             ADDR_WIDTH     = 32,
  parameter int                             DATA_WIDTH     = 32,
  parameter int                             SEL_WIDTH      = DATA_WIDTH/8,
  parameter int                             NUM_SLAVES     = 8,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS   = {32'h3007_0000, 32'h3006_0000, 32'h3005_0000, 32'h3004_0000,
                                                              32'h3003_0000, 32'h3002_0000, 32'h3001_0000, 32'h3000_0000},
  parameter logic [ADDR_WIDTH-1:0]          ADDR_MASK      = 32'hFFFF_0000,
  parameter int                             TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0]          DEFAULT_DATA   = 32'hDEAD_BEEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            m_wb_adr,
  input  logic [DATA_WIDTH-1:0]            m_wb_dat_w,
  input  logic                             m_wb_we,
  input  logic [SEL_WIDTH-1:0]             m_wb_sel,
  input  logic                             m_wb_cyc,
  input  logic                             m_wb_stb,
  output logic [DATA_WIDTH-1:0]            m_wb_dat_r,
  output logic                             m_wb_ack,
  output logic                             m_wb_err,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] s_wb_adr,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0] s_wb_dat_w,
  output logic [NUM_SLAVES*SEL_WIDTH-1:0]  s_wb_sel,
  output logic [NUM_SLAVES-1:0]            s_wb_we,
  output logic [NUM_SLAVES-1:0]            s_wb_cyc,
  output logic [NUM_SLAVES-1:0]            s_wb_stb,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_wb_dat_r,
  input  logic [NUM_SLAVES-1:0]            s_wb_ack,
  input  logic [NUM_SLAVES-1:0]            s_wb_err,
  output logic                             timeout_evt
);

  localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t                       state, next_state;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]        dat_r_q, dat_r_d;
  logic                         ack_q, ack_d, err_q, err_d, tmo_q, tmo_d;
  logic [NUM_SLAVES*ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] dat_w_q, dat_w_d;
  logic [NUM_SLAVES*SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [NUM_SLAVES-1:0]        we_q, we_d, act_q, act_d;

  logic                         hit;
  logic [IDX_W-1:0]             hit_idx;
  logic                         cur_ack, cur_err;
  logic [DATA_WIDTH-1:0]        cur_dat;

  // Descending scan so the lowest matching window is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_wb_adr & ADDR_MASK) == BASE_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign cur_ack = s_wb_ack[idx_q];
  assign cur_err = s_wb_err[idx_q];
  assign cur_dat = s_wb_dat_r[idx_q*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    next_state = state;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    dat_r_d    = dat_r_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    tmo_d      = 1'b0;
    adr_d      = adr_q;
    dat_w_d    = dat_w_q;
    sel_d      = sel_q;
    we_d       = we_q;
    act_d      = act_q;
    case (state)
      IDLE: begin
        if (m_wb_cyc && m_wb_stb) begin
          if (hit) begin
            idx_d                                     = hit_idx;
            adr_d[hit_idx*ADDR_WIDTH +: ADDR_WIDTH]   = m_wb_adr;
            dat_w_d[hit_idx*DATA_WIDTH +: DATA_WIDTH] = m_wb_dat_w;
            sel_d[hit_idx*SEL_WIDTH +: SEL_WIDTH]     = m_wb_sel;
            we_d                                      = '0;
            we_d[hit_idx]                             = m_wb_we;
            act_d                                     = '0;
            act_d[hit_idx]                            = 1'b1;
            cnt_d                                     = '0;
            next_state                                = BUSY;
          end else begin
            err_d      = 1'b1;
            dat_r_d    = DEFAULT_DATA;
            next_state = DONE;
          end
        end
      end
      BUSY: begin
        if (!m_wb_cyc) begin
          act_d      = '0;
          we_d       = '0;
          next_state = IDLE;
        end else if (cur_err) begin
          err_d      = 1'b1;
          dat_r_d    = DEFAULT_DATA;
          act_d      = '0;
          we_d       = '0;
          next_state = DONE;
        end else if (cur_ack) begin
          ack_d      = 1'b1;
          dat_r_d    = cur_dat;
          act_d      = '0;
          we_d       = '0;
          next_state = DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          err_d      = 1'b1;
          tmo_d      = 1'b1;
          dat_r_d    = DEFAULT_DATA;
          act_d      = '0;
          we_d       = '0;
          next_state = DONE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      dat_r_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      adr_q   <= '0;
      dat_w_q <= '0;
      sel_q   <= '0;
      we_q    <= '0;
      act_q   <= '0;
    end else begin
      state   <= next_state;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dat_r_q <= dat_r_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      adr_q   <= adr_d;
      dat_w_q <= dat_w_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      act_q   <= act_d;
    end
  end

  assign m_wb_dat_r  = dat_r_q;
  assign m_wb_ack    = ack_q;
  assign m_wb_err    = err_q;
  assign timeout_evt = tmo_q;
  assign s_wb_adr    = adr_q;
  assign s_wb_dat_w  = dat_w_q;
  assign s_wb_sel    = sel_q;
  assign s_wb_we     = we_q;
  assign s_wb_cyc    = act_q;
  assign s_wb_stb    = act_q;

endmodule

// File: tb/tb_wishbone_bus_router.sv
// tb/tb_wishbone_bus_router.sv - directed self-checking bench for wishbone_bus_router
module tb_wishbone_bus_router;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  m_adr = '0;
  logic [31:0]  m_dat_w = '0;
  logic         m_we = 1'b0;
  logic [3:0]   m_sel = '0;
  logic         m_cyc = 1'b0;
  logic         m_stb = 1'b0;
  logic [31:0]  m_dat_r;
  logic         m_ack, m_err, tmo;
  logic [255:0] s_adr, s_dat_w;
  logic [31:0]  s_sel;
  logic [7:0]   s_we, s_cyc, s_stb;
  logic [255:0] s_dat_r = '0;
  logic [7:0]   s_ack = '0;
  logic [7:0]   s_err = '0;

  int tests = 0;
  int fails = 0;
  int n;

  wishbone_bus_router #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m_wb_adr(m_adr), .m_wb_dat_w(m_dat_w), .m_wb_we(m_we), .m_wb_sel(m_sel),
    .m_wb_cyc(m_cyc), .m_wb_stb(m_stb),
    .m_wb_dat_r(m_dat_r), .m_wb_ack(m_ack), .m_wb_err(m_err),
    .s_wb_adr(s_adr), .s_wb_dat_w(s_dat_w), .s_wb_sel(s_sel),
    .s_wb_we(s_we), .s_wb_cyc(s_cyc), .s_wb_stb(s_stb),
    .s_wb_dat_r(s_dat_r), .s_wb_ack(s_ack), .s_wb_err(s_err),
    .timeout_evt(tmo)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    m_adr = adr; m_we = we; m_dat_w = dat; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
  endtask

  task automatic release_bus;
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
  endtask

  initial begin
    tick; tick;
    check("reset_stb", {56'd0, s_stb}, 64'h0);
    check("reset_resp", {61'd0, m_ack, m_err, tmo}, 64'h0);
    check("reset_dat", {32'd0, m_dat_r}, 64'h0);
    rst = 1'b0;
    tick;

    // zero-wait write to slave 3
    request(32'h3003_0010, 1'b1, 32'h1234_5678);
    tick;
    check("wr_stb", {56'd0, s_stb}, 64'h08);
    check("wr_cyc", {56'd0, s_cyc}, 64'h08);
    check("wr_adr", {32'd0, s_adr[3*32 +: 32]}, 64'h3003_0010);
    check("wr_dat", {32'd0, s_dat_w[3*32 +: 32]}, 64'h1234_5678);
    check("wr_we", {56'd0, s_we}, 64'h08);
    check("wr_noack_yet", {63'd0, m_ack}, 64'h0);
    s_ack[3] = 1'b1;
    tick;
    s_ack[3] = 1'b0;
    release_bus;
    check("wr_ack", {62'd0, m_ack, m_err}, 64'h2);
    check("wr_stb_drop", {56'd0, s_stb}, 64'h0);
    tick;
    check("wr_ack_pulse", {63'd0, m_ack}, 64'h0);
    tick;

    // read slave 5 with 4 wait states; stray ack from slave 0 must be ignored
    request(32'h3005_0004, 1'b0, 32'h0);
    tick;
    check("rd_stb", {56'd0, s_stb}, 64'h20);
    check("rd_we", {56'd0, s_we}, 64'h00);
    s_ack[0] = 1'b1;
    s_dat_r[0 +: 32] = 32'h0BAD_0BAD;
    repeat (4) tick;
    check("rd_wait_noack", {62'd0, m_ack, m_err}, 64'h0);
    check("rd_wait_stb", {56'd0, s_stb}, 64'h20);
    s_ack = 8'h20;
    s_dat_r[5*32 +: 32] = 32'hCAFE_F00D;
    tick;
    s_ack = '0;
    release_bus;
    check("rd_ack", {62'd0, m_ack, m_err}, 64'h2);
    check("rd_dat", {32'd0, m_dat_r}, 64'hCAFE_F00D);
    tick;
    check("rd_ack_pulse", {63'd0, m_ack}, 64'h0);
    tick;

    // unmapped read, then a mapped read to slave 0
    request(32'h4000_0000, 1'b0, 32'h0);
    tick;
    release_bus;
    check("um_err", {62'd0, m_ack, m_err}, 64'h1);
    check("um_dat", {32'd0, m_dat_r}, 64'hDEAD_BEEF);
    check("um_cyc", {56'd0, s_cyc}, 64'h0);
    tick;
    check("um_err_pulse", {63'd0, m_err}, 64'h0);
    tick;
    request(32'h3000_0000, 1'b0, 32'h0);
    tick;
    check("m0_stb", {56'd0, s_stb}, 64'h01);
    s_ack[0] = 1'b1;
    s_dat_r[0 +: 32] = 32'h0000_1111;
    tick;
    s_ack = '0;
    release_bus;
    check("m0_ack", {62'd0, m_ack, m_err}, 64'h2);
    check("m0_dat", {32'd0, m_dat_r}, 64'h0000_1111);
    tick; tick;

    // timeout on slave 2: strobe must be held exactly 8 cycles
    request(32'h3002_0000, 1'b0, 32'h0);
    tick;
    n = 0;
    for (int k = 0; k < 20 && s_stb[2]; k++) begin
      n++;
      tick;
    end
    release_bus;
    check("to_len", 64'(n), 64'd8);
    check("to_err_evt", {61'd0, m_ack, m_err, tmo}, 64'h3);
    check("to_dat", {32'd0, m_dat_r}, 64'hDEAD_BEEF);
    tick;
    check("to_pulse", {62'd0, m_err, tmo}, 64'h0);
    tick;

    // ack in the 8th strobe cycle beats the timeout
    request(32'h3002_0000, 1'b0, 32'h0);
    tick;
    repeat (7) tick;
    check("late_stb", {56'd0, s_stb}, 64'h04);
    s_ack[2] = 1'b1;
    s_dat_r[2*32 +: 32] = 32'hA5A5_0008;
    tick;
    s_ack = '0;
    release_bus;
    check("late_ack", {61'd0, m_ack, m_err, tmo}, 64'h4);
    check("late_dat", {32'd0, m_dat_r}, 64'hA5A5_0008);
    tick; tick;

    // simultaneous ack and err from slave 1
    request(32'h3001_0000, 1'b0, 32'h0);
    tick;
    s_ack[1] = 1'b1;
    s_err[1] = 1'b1;
    tick;
    s_ack = '0;
    s_err = '0;
    release_bus;
    check("ov_err", {61'd0, m_ack, m_err, tmo}, 64'h2);
    check("ov_dat", {32'd0, m_dat_r}, 64'hDEAD_BEEF);
    tick; tick;

    // master abort on slave 6
    request(32'h3006_0000, 1'b0, 32'h0);
    tick;
    check("ab_stb", {56'd0, s_stb}, 64'h40);
    release_bus;
    tick;
    check("ab_drop", {48'd0, s_cyc, s_stb}, 64'h0);
    check("ab_noresp", {62'd0, m_ack, m_err}, 64'h0);
    tick;
    check("ab_noresp2", {62'd0, m_ack, m_err}, 64'h0);

    // stb dropped while cyc held: transfer still completes
    request(32'h3004_0000, 1'b0, 32'h0);
    tick;
    m_stb = 1'b0;
    tick;
    check("stb_hold", {56'd0, s_stb}, 64'h10);
    s_ack[4] = 1'b1;
    s_dat_r[4*32 +: 32] = 32'h4444_0004;
    tick;
    s_ack = '0;
    release_bus;
    check("stb_ack", {62'd0, m_ack, m_err}, 64'h2);
    tick; tick;

    // asynchronous reset mid-transfer on slave 7
    request(32'h3007_0000, 1'b0, 32'h0);
    tick;
    check("rs_stb", {56'd0, s_stb}, 64'h80);
    rst = 1'b1;
    #1;
    check("rs_drop", {48'd0, s_cyc, s_stb}, 64'h0);
    check("rs_resp", {61'd0, m_ack, m_err, tmo}, 64'h0);
    release_bus;
    @(negedge clk);
    rst = 1'b0;
    tick;
    check("rs_idle", {58'd0, s_stb, m_ack, m_err}, 64'h0);
    request(32'h3007_0000, 1'b0, 32'h0);
    tick;
    check("rs_restart", {56'd0, s_stb}, 64'h80);
    release_bus;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
